// File: rtl/s_bank_loader.sv
// s_bank_loader: scatters 64-bit DMA words across NBANK S-bank A ports.
// Each word is split into two DW halves, and the halves are written
// round-robin across the banks starting at a programmable row.
// Optional feature: define S_LOADER_CHECKSUM_EN to build an XOR checksum
// of every written word; otherwise checksum is tied to 0.
module s_bank_loader #(
    parameter int NBANK = 5,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [AW-1:0]                 base_row,
    input  logic [11:0]                   word_count,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2*DW-1:0]               in_data,
    output logic [NBANK-1:0]              S_ena,
    output logic [NBANK-1:0]              S_wea,
    output logic [NBANK-1:0][AW-1:0]      S_addra,
    output logic [NBANK-1:0][DW-1:0]      S_dina,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [DW-1:0]                 checksum
);

    localparam int IW = (NBANK > 1) ? $clog2(NBANK) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           row_q, row_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [11:0]             rem_q, rem_d;
    logic [DW-1:0]           hold_q, hold_d;
    logic                    wr_en;
    logic [DW-1:0]           wr_data;
    logic                    cnt_legal, start_ok, start_bad;

    logic [NBANK-1:0]          ena_q;
    logic [NBANK-1:0][AW-1:0]  addr_q;
    logic [NBANK-1:0][DW-1:0]  dina_q;
    logic                      done_q, error_q;

    // A count is legal when it fits the banks: 1 .. NBANK*512 words.
    assign cnt_legal = (word_count != 12'd0) && (word_count <= 12'(NBANK * 512));
    assign start_ok  = (state_q == IDLE) && start && cnt_legal;
    assign start_bad = (state_q == IDLE) && start && !cnt_legal;

    // Next-state logic: sequencing, write selection and bank/row advance.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    row_d   = base_row;
                    idx_d   = '0;
                    rem_d   = word_count;
                    state_d = LO;
                end
            end
            LO: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_data = in_data[DW-1:0];
                    hold_d  = in_data[2*DW-1:DW];
                    rem_d   = rem_q - 12'd1;
                    state_d = (rem_q == 12'd1) ? FIN : HI;
                end
            end
            HI: begin
                wr_en   = 1'b1;
                wr_data = hold_q;
                rem_d   = rem_q - 12'd1;
                state_d = (rem_q == 12'd1) ? FIN : LO;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Row advances only when the bank index wraps; the row wraps at 512.
        if (wr_en) begin
            if (idx_q == IW'(NBANK - 1)) begin
                idx_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Counters and hold register for the high half.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            idx_q  <= '0;
            rem_q  <= '0;
            hold_q <= '0;
        end else begin
            row_q  <= row_d;
            idx_q  <= idx_d;
            rem_q  <= rem_d;
            hold_q <= hold_d;
        end
    end

    // Registered one-hot bank strobes; unselected banks get zeroed address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena_q   <= '0;
            addr_q  <= '0;
            dina_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                ena_q[b]  <= wr_en && (idx_q == IW'(b));
                addr_q[b] <= (wr_en && (idx_q == IW'(b))) ? row_q : '0;
                dina_q[b] <= (wr_en && (idx_q == IW'(b))) ? wr_data : '0;
            end
            done_q  <= (state_q == FIN);
            error_q <= start_bad;
        end
    end

`ifdef S_LOADER_CHECKSUM_EN
    logic [DW-1:0] chk_q;

    // XOR of every written word, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst)           chk_q <= '0;
        else if (start_ok) chk_q <= '0;
        else if (wr_en)    chk_q <= chk_q ^ wr_data;
    end

    assign checksum = chk_q;
`else
    assign checksum = '0;
`endif

    assign S_ena    = ena_q;
    assign S_wea    = ena_q;
    assign S_addra  = addr_q;
    assign S_dina   = dina_q;
    assign done     = done_q;
    assign error    = error_q;
    assign in_ready = (state_q == LO);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_s_bank_loader.sv
// Directed bench for s_bank_loader: reset, basic load, odd count with row
// wrap, backpressure gaps, illegal counts and checksum.
module tb_s_bank_loader;

    localparam int NBANK = 5;
    localparam int AW    = 9;
    localparam int DW    = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [AW-1:0]             base_row;
    logic [11:0]               word_count;
    logic                      in_valid;
    logic                      in_ready;
    logic [2*DW-1:0]           in_data;
    logic [NBANK-1:0]          S_ena;
    logic [NBANK-1:0]          S_wea;
    logic [NBANK-1:0][AW-1:0]  S_addra;
    logic [NBANK-1:0][DW-1:0]  S_dina;
    logic                      busy;
    logic                      done;
    logic                      error;
    logic [DW-1:0]             checksum;

    int total = 0;
    int bad   = 0;
    logic [63:0] words [0:15];

    s_bank_loader #(.NBANK(NBANK), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_row(base_row),
        .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .S_ena(S_ena), .S_wea(S_wea), .S_addra(S_addra),
        .S_dina(S_dina), .busy(busy), .done(done), .error(error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".ena"},   160'(S_ena),   160'(0));
        chk({tag, ".wea"},   160'(S_wea),   160'(0));
        chk({tag, ".addra"}, 160'(S_addra), 160'(0));
        chk({tag, ".dina"},  160'(S_dina),  160'(0));
    endtask

    // Write n of a load goes to bank n%NBANK at row (base + n/NBANK) mod 512.
    task automatic chk_wr(input int n, input int base, input logic [31:0] d);
        int b;
        logic [NBANK-1:0]         eo;
        logic [NBANK-1:0][AW-1:0] ea;
        logic [NBANK-1:0][DW-1:0] ed;
        b  = n % NBANK;
        eo = '0; ea = '0; ed = '0;
        eo[b] = 1'b1;
        ea[b] = AW'((base + n / NBANK) % 512);
        ed[b] = d;
        chk($sformatf("wr%0d.ena", n),   160'(S_ena),   160'(eo));
        chk($sformatf("wr%0d.wea", n),   160'(S_wea),   160'(eo));
        chk($sformatf("wr%0d.addra", n), 160'(S_addra), 160'(ea));
        chk($sformatf("wr%0d.dina", n),  160'(S_dina),  160'(ed));
    endtask

    task automatic fill(input logic [7:0] salt);
        for (int i = 0; i < 16; i++)
            words[i] = {salt, 24'(2 * i + 1), salt ^ 8'h5A, 24'(2 * i)};
    endtask

    // Full load: start, feed words with optional gaps, check every strobe and done.
    task automatic load(input string tag, input int base, input int cnt, input int gap);
        logic [31:0] x;
        int n, w;
        x = '0; n = 0; w = 0;
        base_row = AW'(base); word_count = 12'(cnt); start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy_t1"},  160'(busy),     160'(1));
        chk({tag, ".ready_t1"}, 160'(in_ready), 160'(1));
        while (n < cnt) begin
            if (w > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    tick();
                    chk({tag, ".gap_ena"},   160'(S_ena),    160'(0));
                    chk({tag, ".gap_ready"}, 160'(in_ready), 160'(1));
                end
            end
            in_valid = 1'b1;
            in_data  = words[w];
            tick();
            in_valid = 1'b0;
            chk_wr(n, base, words[w][31:0]);
            x ^= words[w][31:0];
            n++;
            if (n < cnt) begin
                chk({tag, ".ready_hi"}, 160'(in_ready), 160'(0));
                tick();
                chk_wr(n, base, words[w][63:32]);
                x ^= words[w][63:32];
                n++;
                if (n < cnt) chk({tag, ".ready_lo"}, 160'(in_ready), 160'(1));
            end
            w++;
        end
        chk({tag, ".done_early"}, 160'(done), 160'(0));
        chk({tag, ".busy_last"},  160'(busy), 160'(1));
        tick();
        chk({tag, ".done"},     160'(done),     160'(1));
        chk({tag, ".busy_end"}, 160'(busy),     160'(0));
        chk({tag, ".ena_end"},  160'(S_ena),    160'(0));
        chk({tag, ".ready_end"},160'(in_ready), 160'(0));
`ifdef S_LOADER_CHECKSUM_EN
        chk({tag, ".checksum"}, 160'(checksum), 160'(x));
`else
        chk({tag, ".checksum"}, 160'(checksum), 160'(0));
`endif
        tick();
        chk({tag, ".done_pulse"}, 160'(done), 160'(0));
    endtask

    task automatic illegal(input string tag, input int cnt);
        base_row = '0; word_count = 12'(cnt); start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".error"}, 160'(error), 160'(1));
        chk({tag, ".busy"},  160'(busy),  160'(0));
        chk_quiet(tag);
        tick();
        chk({tag, ".error_pulse"}, 160'(error), 160'(0));
        chk({tag, ".busy2"},       160'(busy),  160'(0));
        chk_quiet({tag, "2"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_row = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst.ready", 160'(in_ready), 160'(0));
        chk("rst.busy",  160'(busy),     160'(0));
        chk("rst.done",  160'(done),     160'(0));
        chk("rst.error", 160'(error),    160'(0));
        chk("rst.chk",   160'(checksum), 160'(0));
        chk_quiet("rst");

        // Reset after three writes, then reload from a new base.
        fill(8'hC3);
        base_row = 9'd3; word_count = 12'd10; start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = words[0];
        tick();
        in_valid = 1'b0;
        chk_wr(0, 3, words[0][31:0]);
        tick();
        chk_wr(1, 3, words[0][63:32]);
        in_valid = 1'b1; in_data = words[1];
        tick();
        in_valid = 1'b0;
        chk_wr(2, 3, words[1][31:0]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.ready", 160'(in_ready), 160'(0));
        chk("midrst.busy",  160'(busy),     160'(0));
        chk("midrst.done",  160'(done),     160'(0));
        chk("midrst.error", 160'(error),    160'(0));
        chk("midrst.chk",   160'(checksum), 160'(0));
        chk_quiet("midrst");
        fill(8'h3C);
        load("after_rst", 7, 4, 0);

        // Basic 10-word load from row 0.
        fill(8'h11);
        load("basic", 0, 10, 0);

        // Odd count across the row 511 -> 0 wrap.
        fill(8'h22);
        load("odd_wrap", 511, 7, 0);

        // Same sequence with 4-cycle stalls between words.
        fill(8'h33);
        load("stall", 0, 10, 4);

        // Illegal counts.
        illegal("cnt0", 0);
        illegal("cnt2561", 2561);

        // Known-value checksum: 1111.. ^ 2222.. ^ 4444.. ^ 8888.. = FFFF_FFFF.
        words[0] = 64'h2222_2222_1111_1111;
        words[1] = 64'h8888_8888_4444_4444;
        load("cksum", 100, 4, 0);
`ifdef S_LOADER_CHECKSUM_EN
        chk("cksum.known", 160'(checksum), 160'(32'hFFFF_FFFF));
`else
        chk("cksum.known", 160'(checksum), 160'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s_bank_loader.md
# s_bank_loader

Stream-to-bank scatter stage that sits directly upstream of the five S-field `bitram` banks. It accepts 64-bit words from the DMA path through a valid/ready handshake and splits each word into two 32-bit halves. The halves are written round-robin across the banks' A ports, starting at a programmable row. It owns the A-port write side of the S banks during a load and reports completion with a `done` pulse.

## Interface
- `NBANK`, 5, number of S banks written round-robin
- `AW`, 9, bank address width (512 rows per bank)
- `DW`, 32, bank data width; input word is 2*DW
- `clk`  input  1  single clock; drives all state and the bank A ports
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  one-cycle pulse; latches `base_row` and `word_count`
- `base_row`  input  AW  first row written in every bank
- `word_count`  input  12  number of 32-bit words to write, legal range 1..NBANK*512 (2560)
- `in_valid`  input  1  DMA word valid
- `in_ready`  output  1  loader can accept `in_data` this cycle
- `in_data`  input  2*DW  DMA word; [31:0] is written first, then [63:32]
- `S_ena`  output  NBANK  per-bank A-port enable
- `S_wea`  output  NBANK  per-bank A-port write enable, one bit per bank
- `S_addra`  output  NBANK*AW  per-bank A-port address, packed [NBANK-1:0][AW-1:0]
- `S_dina`  output  NBANK*DW  per-bank A-port data, packed [NBANK-1:0][DW-1:0]
- `busy`  output  1  high from the cycle after an accepted `start` until `done`
- `done`  output  1  one-cycle pulse after the final write
- `error`  output  1  one-cycle pulse when `start` carries an illegal `word_count`
- `checksum`  output  DW  XOR of all written words (see Configuration)

## Operation
- States: IDLE, LO, HI, FIN.
- IDLE:
  - `start` with a legal `word_count` latches `base_row` into the row counter, sets the bank index to 0 and the remaining count to `word_count`, then goes to LO.
  - `start` with `word_count` of 0 or greater than 2560 pulses `error` the next cycle and stays in IDLE.
- LO:
  - `in_ready`=1.
  - On `in_valid & in_ready`: register a write of `in_data[31:0]`, store `in_data[63:32]` in the hold register, and decrement the remaining count.
  - If the remaining count reaches 0, go to FIN; otherwise go to HI.
- HI:
  - `in_ready`=0.
  - Register a write of the held high half and decrement the remaining count.
  - If the remaining count reaches 0, go to FIN; otherwise go to LO.
- FIN: pulse `done`, drop `busy`, go to IDLE.
- Write targeting:
  - Each write goes to bank `idx` at row `row`.
  - After each write `idx` increments. At the wrap from NBANK-1 to 0, `row` increments modulo 512 (row 511 wraps to 0).
- Only one bank has `S_ena`/`S_wea` high in any cycle. All other banks' enables are 0, and their `S_addra`/`S_dina` are don't-care (driven 0).
- Odd `word_count`: the high half of the last input word is discarded, and no HI write is issued for it.
- `start` while `busy` is ignored.
- Reset mid-load:
  - The state returns to IDLE and all outputs are 0 on the next cycle.
  - Rows already written stay in RAM; no rollback.

## Timing
- Reset values: `in_ready`, `S_ena`, `S_wea`, `S_addra`, `S_dina`, `busy`, `done`, `error`, and `checksum` are all 0.
- `start` sampled at cycle t:
  - `busy`=1 and `in_ready`=1 at t+1.
  - For an illegal count, `error`=1 at t+1 only.
- Word accepted at cycle a:
  - Low-half write is visible on the bank ports at a+1.
  - High-half write is visible at a+2.
  - The next acceptance is possible at a+2 at the earliest, so sustained throughput is one 64-bit word per 2 cycles.
- Write strobes are registered and last exactly one cycle.
- `done` is asserted the cycle after the final write strobe. `busy` falls in the same cycle.
- Stalls (`in_valid`=0 in LO) hold all counters and produce no strobe.

## Configuration
- `S_LOADER_CHECKSUM_EN` defined:
  - `checksum` is cleared on an accepted `start` and XOR-accumulates every 32-bit word written.
  - It is stable and valid from the `done` cycle until the next `start`.
- Not defined: the accumulator is not built and `checksum` is tied to 0.

## Test plan
- Reset mid-load: reset after 3 writes. All outputs are 0 the next cycle, `in_ready`=0, and a following legal `start` loads correctly from `base_row`.
- Basic load: `base_row`=0, `word_count`=10, feed 5 words back-to-back.
  - Writes go to banks 0..4 at row 0, then banks 0..4 at row 1.
  - `in_ready` toggles 1/0.
  - `done` comes 1 cycle after the 10th strobe.
- Odd count and wrap: `base_row`=511, `word_count`=7.
  - Banks 0..4 are written at row 511, then banks 0..1 at row 0.
  - The upper half of the 4th word is never written.
- Backpressure: `in_valid` low for 4 cycles between words. No strobes appear during the gap, and the bank/row sequence is identical to the unstalled run.
- Illegal counts: `word_count`=0, then `word_count`=2561. Each gives an `error` pulse at t+1, `busy` stays 0, and there are no strobes.
- Checksum (macro on): load 0x1111_1111, 0x2222_2222, 0x4444_4444, 0x8888_8888 (2 input words). `checksum`=0xFFFF_FFFF at `done`. With the macro off, `checksum` stays 0.
